// File: rtl/fetch_pkg.sv
// Shared definitions for the program-counter / instruction-fetch sequencer.
package fetch_pkg;

    localparam int          WORD_DEFAULT     = 16;
    localparam logic [15:0] RESET_PC_DEFAULT = 16'h0000;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FETCH  = 2'd1,
        ST_HOLD   = 2'd2,
        ST_HALTED = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/pc_fetch_unit.sv
// PC holder and instruction-fetch sequencer: imem req/ack on one side,
// decode valid/ready on the other, with redirect and halt from execute.
//
// state     | meaning
// ST_IDLE   | just out of reset, first request issued next edge
// ST_FETCH  | request outstanding at PC
// ST_HOLD   | instruction buffered, presented to decode
// ST_HALTED | fetch stopped, PC frozen until Halt drops
module pc_fetch_unit
    import fetch_pkg::*;
#(
    parameter int               WORD     = WORD_DEFAULT,
    parameter logic [WORD-1:0]  RESET_PC = WORD'(RESET_PC_DEFAULT)
) (
    input  logic            Clk,
    input  logic            Reset_n,
    output logic            Imem_Req,
    output logic [WORD-1:0] Imem_Addr,
    input  logic            Imem_Ack,
    input  logic [WORD-1:0] Imem_Data,
    output logic [WORD-1:0] Instr_Out,
    output logic [WORD-1:0] Instr_Pc,
    output logic            Instr_Valid,
    input  logic            Instr_Ready,
    input  logic            Branch_Taken,
    input  logic [WORD-1:0] Branch_Target,
    input  logic            Halt,
    output logic [WORD-1:0] New_Pc_Out
);

    fetch_state_e    state_q, state_d;
    logic [WORD-1:0] pc_q, pc_d;
    logic [WORD-1:0] instr_out_q, instr_out_d;
    logic [WORD-1:0] instr_pc_q, instr_pc_d;
    logic            instr_valid_q, instr_valid_d;
    logic            imem_req_q, imem_req_d;
    logic            squash_q, squash_d;
    logic            ack_seen;

    assign ack_seen = Imem_Ack && imem_req_q;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        instr_out_d   = instr_out_q;
        instr_pc_d    = instr_pc_q;
        instr_valid_d = instr_valid_q;
        imem_req_d    = imem_req_q;
        squash_d      = squash_q;

        case (state_q)
            ST_IDLE: begin
                state_d    = ST_FETCH;
                imem_req_d = 1'b1;
            end
            ST_FETCH: begin
                imem_req_d = 1'b1;
                if (Branch_Taken) begin
                    // An ack arriving now belongs to the old address and is
                    // simply dropped; otherwise the next ack must be dropped.
                    pc_d     = Branch_Target;
                    squash_d = !ack_seen;
                end else if (ack_seen) begin
                    if (squash_q) begin
                        squash_d = 1'b0;
                    end else begin
                        instr_out_d   = Imem_Data;
                        instr_pc_d    = pc_q;
                        instr_valid_d = 1'b1;
                        imem_req_d    = 1'b0;
                        state_d       = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (Branch_Taken) begin
                    pc_d          = Branch_Target;
                    instr_valid_d = 1'b0;
                    imem_req_d    = 1'b1;
                    state_d       = ST_FETCH;
                end else if (instr_valid_q && Instr_Ready) begin
                    pc_d          = pc_q + WORD'(1);
                    instr_valid_d = 1'b0;
                    imem_req_d    = !Halt;
                    state_d       = Halt ? ST_HALTED : ST_FETCH;
                end
            end
            ST_HALTED: begin
                if (Branch_Taken) begin
                    pc_d = Branch_Target;
                end else if (!Halt) begin
                    imem_req_d = 1'b1;
                    state_d    = ST_FETCH;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q       <= ST_IDLE;
            pc_q          <= RESET_PC;
            instr_out_q   <= '0;
            instr_pc_q    <= '0;
            instr_valid_q <= 1'b0;
            imem_req_q    <= 1'b0;
            squash_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_out_q   <= instr_out_d;
            instr_pc_q    <= instr_pc_d;
            instr_valid_q <= instr_valid_d;
            imem_req_q    <= imem_req_d;
            squash_q      <= squash_d;
        end
    end

    assign Imem_Req    = imem_req_q;
    assign Imem_Addr   = pc_q;
    assign Instr_Out   = instr_out_q;
    assign Instr_Pc    = instr_pc_q;
    assign Instr_Valid = instr_valid_q;
    assign New_Pc_Out  = pc_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit with a simple variable-latency memory model.
module tb_pc_fetch_unit;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic        Imem_Req;
    logic [15:0] Imem_Addr;
    logic        Imem_Ack;
    logic [15:0] Imem_Data;
    logic [15:0] Instr_Out;
    logic [15:0] Instr_Pc;
    logic        Instr_Valid;
    logic        Instr_Ready;
    logic        Branch_Taken;
    logic [15:0] Branch_Target;
    logic        Halt;
    logic [15:0] New_Pc_Out;

    int n_tests = 0;
    int n_fail  = 0;

    // memory model: acks after mem_delay wait cycles, returns A000 + address
    // latched when the request started
    int          mem_delay = 0;
    int          wait_cnt  = 0;
    logic        busy      = 1'b0;
    logic [15:0] addr_lat  = 16'h0;
    logic [15:0] cur_addr;

    always #5 Clk = ~Clk;

    pc_fetch_unit #(.WORD(16), .RESET_PC(16'h0000)) dut (
        .Clk           (Clk),
        .Reset_n       (Reset_n),
        .Imem_Req      (Imem_Req),
        .Imem_Addr     (Imem_Addr),
        .Imem_Ack      (Imem_Ack),
        .Imem_Data     (Imem_Data),
        .Instr_Out     (Instr_Out),
        .Instr_Pc      (Instr_Pc),
        .Instr_Valid   (Instr_Valid),
        .Instr_Ready   (Instr_Ready),
        .Branch_Taken  (Branch_Taken),
        .Branch_Target (Branch_Target),
        .Halt          (Halt),
        .New_Pc_Out    (New_Pc_Out)
    );

    assign cur_addr  = busy ? addr_lat : Imem_Addr;
    assign Imem_Ack  = Imem_Req && (wait_cnt >= mem_delay);
    assign Imem_Data = 16'hA000 + cur_addr;

    always @(posedge Clk) begin
        if (!Reset_n || !Imem_Req || Imem_Ack) begin
            busy     <= 1'b0;
            wait_cnt <= 0;
        end else begin
            if (!busy) addr_lat <= Imem_Addr;
            busy     <= 1'b1;
            wait_cnt <= wait_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge Clk);
    endtask

    task automatic wait_valid(input string tag, output int n);
        n = 0;
        while (!Instr_Valid && n < 20) begin
            step();
            n++;
        end
        if (!Instr_Valid) chk({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    initial begin
        int n;
        Reset_n       = 1'b0;
        Instr_Ready   = 1'b0;
        Branch_Taken  = 1'b0;
        Branch_Target = 16'h0;
        Halt          = 1'b0;
        step();
        step();
        chk("rst_req",   Imem_Req,    0);
        chk("rst_valid", Instr_Valid, 0);
        chk("rst_pc",    New_Pc_Out,  0);
        chk("rst_addr",  Imem_Addr,   0);
        chk("rst_out",   Instr_Out,   0);
        chk("rst_ipc",   Instr_Pc,    0);

        // zero-wait streaming
        Reset_n     = 1'b1;
        Instr_Ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("seq_req",    Imem_Req,    1);
            chk("seq_addr",   Imem_Addr,   k);
            chk("seq_novld",  Instr_Valid, 0);
            chk("seq_newpc",  New_Pc_Out,  k);
            step();
            chk("seq_valid",  Instr_Valid, 1);
            chk("seq_out",    Instr_Out,   16'hA000 + k);
            chk("seq_ipc",    Instr_Pc,    k);
            chk("seq_req_lo", Imem_Req,    0);
        end

        // decode stall in HOLD
        Instr_Ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("stall_valid", Instr_Valid, 1);
            chk("stall_out",   Instr_Out,   16'hA003);
            chk("stall_ipc",   Instr_Pc,    3);
            chk("stall_req",   Imem_Req,    0);
            chk("stall_pc",    New_Pc_Out,  3);
        end
        Instr_Ready = 1'b1;
        step();
        chk("after_stall_pc",  New_Pc_Out, 4);
        chk("after_stall_req", Imem_Req,   1);

        // redirect while ack outstanding
        mem_delay = 3;
        step();
        Branch_Taken  = 1'b1;
        Branch_Target = 16'h0040;
        step();
        Branch_Taken = 1'b0;
        chk("sq_addr",  Imem_Addr,  16'h0040);
        chk("sq_req",   Imem_Req,   1);
        chk("sq_newpc", New_Pc_Out, 16'h0040);
        step();
        step();
        chk("sq_dropped", Instr_Valid, 0);
        chk("sq_rereq",   Imem_Req,    1);
        wait_valid("sq", n);
        chk("sq_latency", n,         4);
        chk("sq_out",     Instr_Out, 16'hA040);
        chk("sq_ipc",     Instr_Pc,  16'h0040);
        mem_delay = 0;

        // redirect and ready in the same HOLD cycle
        step();
        chk("br_fetch_addr", Imem_Addr, 16'h0041);
        step();
        chk("br_hold_valid", Instr_Valid, 1);
        Branch_Taken  = 1'b1;
        Branch_Target = 16'h0100;
        step();
        Branch_Taken = 1'b0;
        chk("br_novalid", Instr_Valid, 0);
        chk("br_req",     Imem_Req,    1);
        chk("br_addr",    Imem_Addr,   16'h0100);
        chk("br_newpc",   New_Pc_Out,  16'h0100);
        step();
        chk("br_ipc", Instr_Pc,  16'h0100);
        chk("br_out", Instr_Out, 16'hA100);

        // PC wrap at FFFF
        Branch_Taken  = 1'b1;
        Branch_Target = 16'hFFFF;
        step();
        Branch_Taken = 1'b0;
        chk("wrap_addr", Imem_Addr, 16'hFFFF);
        step();
        chk("wrap_ipc", Instr_Pc,  16'hFFFF);
        chk("wrap_out", Instr_Out, 16'h9FFF);
        step();
        chk("wrap_newpc", New_Pc_Out, 16'h0000);
        chk("wrap_req",   Imem_Req,   1);

        // halt raised mid-fetch
        mem_delay = 2;
        Halt      = 1'b1;
        wait_valid("halt", n);
        chk("halt_latency", n,        3);
        chk("halt_ipc",     Instr_Pc, 16'h0000);
        for (int k = 0; k < 4; k++) begin
            step();
            chk("halted_req",   Imem_Req,    0);
            chk("halted_valid", Instr_Valid, 0);
            chk("halted_pc",    New_Pc_Out,  1);
        end
        Halt      = 1'b0;
        mem_delay = 0;
        step();
        chk("resume_req",  Imem_Req,  1);
        chk("resume_addr", Imem_Addr, 1);

        // async reset mid-FETCH
        Reset_n = 1'b0;
        #1;
        chk("mrst_req",   Imem_Req,    0);
        chk("mrst_pc",    New_Pc_Out,  0);
        chk("mrst_valid", Instr_Valid, 0);
        step();
        chk("mrst_hold_req", Imem_Req, 0);
        Reset_n = 1'b1;
        step();
        chk("post_rst_req",  Imem_Req,  1);
        chk("post_rst_addr", Imem_Addr, 0);
        step();
        chk("post_rst_ipc", Instr_Pc,  0);
        chk("post_rst_out", Instr_Out, 16'hA000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
